logical_ops_pipe: RTL



---
 rtl/logical_ops_pipe.sv | 83 ++++++++
 1 files changed

// File: rtl/logical_ops_pipe.sv
// logical_ops_pipe: two-stage valid/ready 8-function logical unit with accumulator operand and result flags
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     operand beat handshake (A, B, Operation, in_acc)
//   out_valid/out_ready   result beat handshake (out, flag_zero, flag_parity, flag_ovf)
//   in_acc                replaces B with the most recent result loaded into stage 2
module logical_ops_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_zero,
    output logic             flag_parity,
    output logic             flag_ovf
);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic             s1_valid, s1_acc, s2_valid, s1_load, s2_load;
    logic [WIDTH-1:0] s1_a, s1_b, acc, opb, res;
    logic [2:0]       s1_op;
    // out_ready reaches in_ready combinationally so a draining S2 lets S1 refill in the same cycle
    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign opb       = s1_acc ? acc : s1_b;
    always_comb begin
        res = '0;
        case (s1_op)
            3'd0:    res = s1_a & opb;
            3'd1:    res = s1_a | opb;
            3'd2:    res = ~s1_a;
            3'd3:    res = s1_a ^ opb;
            3'd4:    res = ~(s1_a & opb);
            3'd5:    res = ~(s1_a | opb);
            3'd6:    res = ~(s1_a ^ opb);
            default: res = ~s1_a + 1'b1;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_acc   <= 1'b0;
        end else begin
            s1_valid <= s1_load | (s1_valid & ~s2_load);
            if (s1_load) begin
                s1_a   <= A;
                s1_b   <= B;
                s1_op  <= Operation;
                s1_acc <= in_acc;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            out         <= '0;
            acc         <= '0;
            flag_zero   <= 1'b1;
            flag_parity <= 1'b0;
            flag_ovf    <= 1'b0;
        end else begin
            s2_valid <= s2_load | (s2_valid & ~out_ready);
            if (s2_load) begin
                out         <= res;
                acc         <= res;
                flag_zero   <= res == '0;
                flag_parity <= ^res;
                flag_ovf    <= (s1_op == 3'd7) && (s1_a == MIN_NEG);
            end
        end
    end
endmodule
